gpu_fetch_unit: RTL and testbench

Instruction fetch stage of the GPU core pipeline, directly upstream of the control unit / decode stage. It owns the program counter, issues reads to the synchronous instruction memory, and buffers returned instructions in a 2-entry skid buffer. It presents one instruction per cycle to decode with a valid/stall handshake. It also handles start, branch redirect and halt.

---
 rtl/gpu_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_gpu_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_fetch_unit.sv
// gpu_fetch_unit
// Instruction fetch stage: owns the PC, issues reads to a synchronous
// instruction memory (1-cycle read latency) and buffers returned words in a
// 2-entry skid buffer presented to decode with a valid/stall handshake.
// Handles start, branch redirect and halt.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   start, start_pc   begin fetching at start_pc (honoured in IDLE/HALTED)
//   stall             decode cannot accept this cycle
//   redirect_valid/pc taken branch: flush buffer and refetch from redirect_pc
//   halt_req          decode accepted a HALT this cycle
//   imem_addr_out     IMEM read address (registered PC)
//   imem_rd_en        IMEM read issued this cycle (combinational credit check)
//   imem_data_in      IMEM read data, valid one cycle after imem_rd_en
//   instr_out/pc      buffer-head instruction and its fetch address
//   instr_valid       buffer head is valid
//   running           fetch FSM is in RUN
module gpu_fetch_unit #(
    parameter int unsigned PC_WIDTH    = 9,
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [PC_WIDTH-1:0]    start_pc,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    input  logic                   halt_req,
    output logic [PC_WIDTH-1:0]    imem_addr_out,
    output logic                   imem_rd_en,
    input  logic [INSTR_WIDTH-1:0] imem_data_in,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [PC_WIDTH-1:0]    instr_pc,
    output logic                   instr_valid,
    output logic                   running
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]    pc;
    } entry_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] tag_pc;     // address of the read currently in flight
    logic [1:0]          count;      // valid skid-buffer entries, 0..2
    logic                inflight;   // a read issued last cycle returns now
    entry_t              slot0;      // buffer head
    entry_t              slot1;

    logic                accept;
    logic                issue;
    logic [2:0]          occupancy;
    entry_t              resp;

    // Handshake and credit check: issue only if the word can be guaranteed a
    // slot once it returns, counting the head leaving this cycle as credit.
    always_comb begin
        accept    = (count != 2'd0) && !stall;
        occupancy = 3'(count) + 3'(inflight);
        issue     = (state == S_RUN) && !rst && !halt_req && !redirect_valid
                    && (occupancy < (3'd2 + 3'(accept)));
        resp      = '{instr: imem_data_in, pc: tag_pc};
    end

    // Fetch FSM, PC, in-flight tracking and skid buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= '0;
            tag_pc   <= '0;
            count    <= 2'd0;
            inflight <= 1'b0;
            slot0    <= '0;
            slot1    <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        state    <= S_RUN;
                        pc       <= start_pc;
                        count    <= 2'd0;
                        inflight <= 1'b0;
                    end
                end

                S_RUN: begin
                    if (halt_req) begin
                        // Drop buffered and returning words; no further reads.
                        state    <= S_HALTED;
                        count    <= 2'd0;
                        inflight <= 1'b0;
                    end else if (redirect_valid) begin
                        // Flush; the response arriving this cycle is not pushed
                        // and nothing is issued, so nothing stale remains.
                        pc       <= redirect_pc;
                        count    <= 2'd0;
                        inflight <= 1'b0;
                    end else begin
                        if (issue) begin
                            pc     <= pc + PC_WIDTH'(1);
                            tag_pc <= pc;
                        end
                        inflight <= issue;

                        // Push is the returning response, pop is the accept.
                        case ({inflight, accept})
                            2'b10: begin
                                if (count == 2'd0) begin
                                    slot0 <= resp;
                                end else begin
                                    slot1 <= resp;
                                end
                                count <= count + 2'd1;
                            end
                            2'b01: begin
                                slot0 <= slot1;
                                count <= count - 2'd1;
                            end
                            2'b11: begin
                                if (count == 2'd1) begin
                                    slot0 <= resp;
                                end else begin
                                    slot0 <= slot1;
                                    slot1 <= resp;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign imem_addr_out = pc;
    assign imem_rd_en    = issue;
    assign instr_out     = slot0.instr;
    assign instr_pc      = slot0.pc;
    assign instr_valid   = (count != 2'd0);
    assign running       = (state == S_RUN);

endmodule

// File: tb/tb_gpu_fetch_unit.sv
// Directed bench for gpu_fetch_unit with a synchronous IMEM model whose
// word[a] = 0xA000_0000 | a.
module tb_gpu_fetch_unit;

    localparam int unsigned PW = 9;
    localparam int unsigned IW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [PW-1:0] start_pc;
    logic          stall;
    logic          redirect_valid;
    logic [PW-1:0] redirect_pc;
    logic          halt_req;
    logic [PW-1:0] imem_addr_out;
    logic          imem_rd_en;
    logic [IW-1:0] imem_data_in;
    logic [IW-1:0] instr_out;
    logic [PW-1:0] instr_pc;
    logic          instr_valid;
    logic          running;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    gpu_fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .start_pc       (start_pc),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .imem_addr_out  (imem_addr_out),
        .imem_rd_en     (imem_rd_en),
        .imem_data_in   (imem_data_in),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .running        (running)
    );

    always #5 clk = ~clk;

    // Synchronous IMEM: data for the address presented in cycle k appears in k+1.
    always @(posedge clk) imem_data_in <= 32'hA000_0000 | 32'(imem_addr_out);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_instr(input string tag, input logic [PW-1:0] pc);
        chk({tag, "/valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "/pc"},    32'(instr_pc),    32'(pc));
        chk({tag, "/instr"}, instr_out,        32'hA000_0000 | 32'(pc));
    endtask

    task automatic exp_empty(input string tag);
        chk({tag, "/valid"}, 32'(instr_valid), 32'd0);
    endtask

    task automatic exp_issue(input string tag, input logic en, input logic [PW-1:0] addr);
        chk({tag, "/rd_en"}, 32'(imem_rd_en), 32'(en));
        if (en) chk({tag, "/addr"}, 32'(imem_addr_out), 32'(addr));
    endtask

    task automatic exp_reset_outputs(input string tag);
        chk({tag, "/addr"},    32'(imem_addr_out), 32'd0);
        chk({tag, "/rd_en"},   32'(imem_rd_en),    32'd0);
        chk({tag, "/instr"},   instr_out,          32'd0);
        chk({tag, "/ipc"},     32'(instr_pc),      32'd0);
        chk({tag, "/valid"},   32'(instr_valid),   32'd0);
        chk({tag, "/running"}, 32'(running),       32'd0);
    endtask

    task automatic rand_inputs();
        start          = 1'($urandom);
        start_pc       = PW'($urandom);
        stall          = 1'($urandom);
        redirect_valid = 1'($urandom);
        redirect_pc    = PW'($urandom);
        halt_req       = 1'($urandom);
    endtask

    task automatic quiet_inputs();
        start          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
    endtask

    initial begin
        // ---------------- reset with random inputs ----------------
        rst = 1'b1;
        rand_inputs();
        for (int i = 0; i < 2; i++) begin
            tick();
            rand_inputs();
            #1;
            exp_reset_outputs("reset");
        end
        rst = 1'b0;
        quiet_inputs();
        start_pc    = '0;
        redirect_pc = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle/rd_en",   32'(imem_rd_en), 32'd0);
            chk("idle/running", 32'(running),    32'd0);
        end

        // ---------------- streaming from 0x010 ----------------
        start    = 1'b1;
        start_pc = 9'h010;
        #1;
        exp_issue("pre_start", 1'b0, '0);
        tick();                                   // edge T0 sampled start
        start = 1'b0;
        #1;
        chk("t1/running", 32'(running), 32'd1);
        exp_issue("t1", 1'b1, 9'h010);
        exp_empty("t1");
        tick();
        exp_issue("t2", 1'b1, 9'h011);
        exp_empty("t2");
        tick();
        exp_instr("t3", 9'h010);                  // latency 3
        exp_issue("t3", 1'b1, 9'h012);
        tick();
        exp_instr("t4", 9'h011);

        // ---------------- stall for 4 cycles after 2nd accept ----------------
        for (int i = 0; i < 4; i++) begin
            tick();
            stall = 1'b1;
            #1;
            exp_instr("stall", 9'h012);
            exp_issue("stall", 1'b0, '0);
        end
        tick();
        stall = 1'b0;
        #1;
        exp_issue("release", 1'b1, 9'h014);       // issue resumes same cycle
        for (int i = 0; i < 5; i++) begin
            exp_instr("resume", PW'(9'h012 + i));
            tick();
        end

        // ---------------- redirect while saturated ----------------
        stall = 1'b1;                             // head 0x017, 0x018 in flight
        #1;
        exp_instr("sat0", 9'h017);
        exp_issue("sat0", 1'b0, '0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 9'h040;
        #1;
        exp_instr("sat1", 9'h017);
        exp_issue("redir_cyc", 1'b0, '0);
        tick();                                   // edge R
        redirect_valid = 1'b0;
        stall          = 1'b0;
        #1;
        exp_empty("r1");
        exp_issue("r1", 1'b1, 9'h040);
        tick();
        exp_empty("r2");
        exp_issue("r2", 1'b1, 9'h041);
        tick();
        exp_instr("r3", 9'h040);
        tick();
        exp_instr("r4", 9'h041);

        // ---------------- halt ----------------
        halt_req = 1'b1;
        tick();                                   // edge H
        halt_req = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("halt/running", 32'(running), 32'd0);
            exp_empty("halt");
            exp_issue("halt", 1'b0, '0);
            tick();
        end

        // ---------------- wrap from 0x1FE, halt on 4th accept ----------------
        start    = 1'b1;
        start_pc = 9'h1FE;
        tick();
        start = 1'b0;
        #1;
        chk("w1/running", 32'(running), 32'd1);
        exp_issue("w1", 1'b1, 9'h1FE);
        tick();
        exp_issue("w2", 1'b1, 9'h1FF);
        exp_empty("w2");
        tick();
        exp_instr("w3", 9'h1FE);
        exp_issue("w3", 1'b1, 9'h000);
        tick();
        exp_instr("w4", 9'h1FF);
        tick();
        exp_instr("w5", 9'h000);
        tick();
        exp_instr("w6", 9'h001);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("whalt/running", 32'(running), 32'd0);
            exp_empty("whalt");
            exp_issue("whalt", 1'b0, '0);
            tick();
        end

        // ---------------- restart at 0x005 ----------------
        start    = 1'b1;
        start_pc = 9'h005;
        tick();
        start = 1'b0;
        #1;
        exp_issue("s1", 1'b1, 9'h005);
        tick();
        exp_empty("s2");
        tick();
        stall = 1'b1;
        #1;
        exp_instr("s3", 9'h005);
        exp_issue("s3", 1'b0, '0);
        tick();
        rst = 1'b1;                               // buffer full at this point
        #1;
        exp_instr("s4", 9'h005);

        // ---------------- reset mid-run ----------------
        tick();
        rst   = 1'b0;
        stall = 1'b0;
        #1;
        exp_reset_outputs("midrst");
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_empty("postrst");
            exp_issue("postrst", 1'b0, '0);
        end
        start    = 1'b1;
        start_pc = 9'h030;
        tick();
        start = 1'b0;
        #1;
        exp_issue("q1", 1'b1, 9'h030);
        exp_empty("q1");
        tick();
        exp_empty("q2");
        tick();
        exp_instr("q3", 9'h030);
        tick();
        exp_instr("q4", 9'h031);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
